// File: rtl/regfile_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file with a pending-write scoreboard.
package regfile_mp_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;
    localparam int DEFAULT_NREAD = 2;

    // Register 0 is hardwired to zero and can never be pending.
    localparam int ZERO_REG = 0;

    // Address width for a given register count; never less than one bit.
    function automatic int addr_width(input int depth);
        if (depth < 2) begin
            return 1;
        end
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: storage lookup with same-cycle write bypass and pending-bit lookup.
// Write enables arriving here are already qualified (reset released, nonzero address).
module regfile_rdport
    import regfile_mp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = addr_width(DEFAULT_DEPTH)
) (
    input  logic [AW-1:0]          ra_i,
    input  logic [DEPTH*WIDTH-1:0] mem_i,
    input  logic [DEPTH-1:0]       pend_i,
    input  logic                   we0_i,
    input  logic [AW-1:0]          wa0_i,
    input  logic [WIDTH-1:0]       wd0_i,
    input  logic                   we1_i,
    input  logic [AW-1:0]          wa1_i,
    input  logic [WIDTH-1:0]       wd1_i,
    output logic [WIDTH-1:0]       rd_o,
    output logic                   rpend_o
);

    logic hit0;
    logic hit1;

    assign hit0 = we0_i && (wa0_i == ra_i);
    assign hit1 = we1_i && (wa1_i == ra_i);

    // Read mux: zero register, then bypass (port 1 over port 0), then stored value.
    always_comb begin
        rd_o    = '0;
        rpend_o = 1'b0;
        if (ra_i != AW'(ZERO_REG)) begin
            if (hit1) begin
                rd_o = wd1_i;
            end else if (hit0) begin
                rd_o = wd0_i;
            end else begin
                rd_o    = mem_i[int'(ra_i)*WIDTH +: WIDTH];
                rpend_o = pend_i[ra_i];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with a one-bit-per-register pending scoreboard.
// Register 0 reads as zero, ignores writes and is never pending. Reads are combinational
// and bypass same-cycle writes; a write clears pending unless an issue hits the same register.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    parameter  int NREAD = DEFAULT_NREAD,
    localparam int AW    = addr_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREAD*AW-1:0]    ra,
    output logic [NREAD*WIDTH-1:0] rd,
    output logic [NREAD-1:0]       rpend,
    input  logic                   we0,
    input  logic [AW-1:0]          wa0,
    input  logic [WIDTH-1:0]       wd0,
    input  logic                   we1,
    input  logic [AW-1:0]          wa1,
    input  logic [WIDTH-1:0]       wd1,
    input  logic                   iss_v,
    input  logic [AW-1:0]          iss_a,
    output logic                   iss_stall
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [DEPTH-1:0][WIDTH-1:0] mem_d;
    logic [DEPTH-1:0]            pend_q;
    logic [DEPTH-1:0]            pend_d;
    logic [DEPTH*WIDTH-1:0]      mem_flat;

    // Qualified controls: nothing takes effect while reset is held, and register 0 is inert.
    logic wr0_en;
    logic wr1_en;
    logic iss_en;

    assign wr0_en = rst_n && we0 && (wa0 != AW'(ZERO_REG));
    assign wr1_en = rst_n && we1 && (wa1 != AW'(ZERO_REG));
    assign iss_en = rst_n && iss_v && (iss_a != AW'(ZERO_REG));

    assign mem_flat = mem_q;

    // Storage next state: port 1 is applied last so it wins on an address collision.
    always_comb begin
        mem_d = mem_q;
        if (wr0_en) begin
            mem_d[wa0] = wd0;
        end
        if (wr1_en) begin
            mem_d[wa1] = wd1;
        end
    end

    // Scoreboard next state: writes clear, then an issue sets, so issue wins on a collision.
    always_comb begin
        pend_d = pend_q;
        if (wr0_en) begin
            pend_d[wa0] = 1'b0;
        end
        if (wr1_en) begin
            pend_d[wa1] = 1'b0;
        end
        if (iss_en) begin
            pend_d[iss_a] = 1'b1;
        end
        pend_d[ZERO_REG] = 1'b0;
    end

    // State registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    // Stall when the issued register is still pending and no write retires it this cycle.
    always_comb begin
        iss_stall = iss_en && pend_q[iss_a]
                    && !(wr0_en && (wa0 == iss_a))
                    && !(wr1_en && (wa1 == iss_a));
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        regfile_rdport #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_rdport (
            .ra_i    (ra[g*AW +: AW]),
            .mem_i   (mem_flat),
            .pend_i  (pend_q),
            .we0_i   (wr0_en),
            .wa0_i   (wa0),
            .wd0_i   (wd0),
            .we1_i   (wr1_en),
            .wa1_i   (wa1),
            .wd1_i   (wd1),
            .rd_o    (rd[g*WIDTH +: WIDTH]),
            .rpend_o (rpend[g])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp at WIDTH=16, DEPTH=8, NREAD=4: architectural model plus directed vectors.
module tb_regfile_mp;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int NR = 4;
    localparam int AW = 3;

    logic              clk;
    logic              rst_n;
    logic [NR*AW-1:0]  ra;
    logic [NR*W-1:0]   rd;
    logic [NR-1:0]     rpend;
    logic              we0;
    logic [AW-1:0]     wa0;
    logic [W-1:0]      wd0;
    logic              we1;
    logic [AW-1:0]     wa1;
    logic [W-1:0]      wd1;
    logic              iss_v;
    logic [AW-1:0]     iss_a;
    logic              iss_stall;

    int errors = 0;
    int checks = 0;

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra        (ra),
        .rd        (rd),
        .rpend     (rpend),
        .we0       (we0),
        .wa0       (wa0),
        .wd0       (wd0),
        .we1       (we1),
        .wa1       (wa1),
        .wd1       (wd1),
        .iss_v     (iss_v),
        .iss_a     (iss_a),
        .iss_stall (iss_stall)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- architectural model ----------------
    logic [W-1:0] model_reg [D] = '{default: '0};
    bit           model_pend [D] = '{default: 1'b0};

    function automatic bit written_now(input logic [AW-1:0] a);
        return rst_n && a != 0 && ((we0 && wa0 == a) || (we1 && wa1 == a));
    endfunction

    function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
        if (!rst_n || a == 0) return '0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return model_reg[a];
    endfunction

    function automatic logic exp_rpend(input logic [AW-1:0] a);
        if (!rst_n || a == 0) return 1'b0;
        if (written_now(a)) return 1'b0;
        return model_pend[a];
    endfunction

    function automatic logic exp_stall();
        if (!rst_n || !iss_v || iss_a == 0) return 1'b0;
        return model_pend[iss_a] && !written_now(iss_a);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < D; r++) begin
                model_reg[r]  = '0;
                model_pend[r] = 1'b0;
            end
        end else begin
            if (we0 && wa0 != 0) begin
                model_reg[wa0]  = wd0;
                model_pend[wa0] = 1'b0;
            end
            if (we1 && wa1 != 0) begin
                model_reg[wa1]  = wd1;
                model_pend[wa1] = 1'b0;
            end
            if (iss_v && iss_a != 0) model_pend[iss_a] = 1'b1;
        end
    end

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        for (int p = 0; p < NR; p++) begin
            logic [AW-1:0] a;
            a = ra[p*AW +: AW];
            checks++;
            if (rd[p*W +: W] !== exp_rd(a)) begin
                errors++;
                $display("FAIL cyc_rd%0d t=%0t addr=%0d got=%h exp=%h", p, $time, a, rd[p*W +: W], exp_rd(a));
            end
            checks++;
            if (rpend[p] !== exp_rpend(a)) begin
                errors++;
                $display("FAIL cyc_rpend%0d t=%0t addr=%0d got=%b exp=%b", p, $time, a, rpend[p], exp_rpend(a));
            end
        end
        checks++;
        if (iss_stall !== exp_stall()) begin
            errors++;
            $display("FAIL cyc_stall t=%0t got=%b exp=%b", $time, iss_stall, exp_stall());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_ra(input logic [AW-1:0] a0, a1, a2, a3);
        ra = {a3, a2, a1, a0};
    endtask

    task automatic idle_writes();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        iss_v = 1'b0; iss_a = '0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rdp(input int p);
        return rd[p*W +: W];
    endfunction

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        idle_writes();
        set_ra(0, 0, 0, 0);

        // Reset holds everything at zero and ignores writes and issues.
        step();
        we0 = 1'b1; wa0 = 3; wd0 = 16'hAAAA;
        iss_v = 1'b1; iss_a = 3;
        set_ra(3, 0, 0, 0);
        #1;
        chk("rst_rd_ignores_write", rdp(0), 16'h0000);
        chk("rst_rpend", W'(rpend), '0);
        chk("rst_stall", W'(iss_stall), '0);
        step();
        chk("rst_rd_after_edge", rdp(0), 16'h0000);
        idle_writes();
        step();
        rst_n = 1'b1;

        // Writes to register 0 are discarded.
        step();
        we0 = 1'b1; wa0 = 0; wd0 = 16'd13;
        set_ra(0, 0, 0, 0);
        #1;
        chk("r0_before_edge", rdp(0), 16'h0000);
        step();
        we0 = 1'b0;
        #1;
        chk("r0_after_edge", rdp(0), 16'h0000);

        // Same-cycle bypass, then the stored value.
        we0 = 1'b1; wa0 = 2; wd0 = 16'd94;
        set_ra(0, 2, 0, 0);
        #1;
        chk("bypass_r2", rdp(1), 16'd94);
        step();
        we0 = 1'b0;
        #1;
        chk("stored_r2", rdp(1), 16'd94);

        // Disabled write has no effect; reads follow the address without a clock.
        we0 = 1'b0; wa0 = 4; wd0 = 16'd100;
        set_ra(4, 2, 0, 0);
        #1;
        chk("no_we_bypass_r4", rdp(0), 16'h0000);
        step();
        #1;
        chk("no_we_store_r4", rdp(0), 16'h0000);
        set_ra(2, 2, 0, 0);
        #1;
        chk("async_read_r2", rdp(0), 16'd94);

        // Both write ports to one address: port 1 wins.
        step();
        we0 = 1'b1; wa0 = 5; wd0 = 16'd7;
        we1 = 1'b1; wa1 = 5; wd1 = 16'd9;
        set_ra(0, 0, 5, 0);
        #1;
        chk("dual_bypass_r5", rdp(2), 16'd9);
        step();
        idle_writes();
        #1;
        chk("dual_store_r5", rdp(2), 16'd9);

        // Scoreboard: issue, re-issue stall, retire by write, issue-wins collision.
        iss_v = 1'b1; iss_a = 3;
        set_ra(0, 0, 0, 3);
        step();
        iss_v = 1'b0;
        #1;
        chk("pend_r3_set", W'(rpend[3]), 16'h0001);
        iss_v = 1'b1; iss_a = 3;
        #1;
        chk("stall_reissue_r3", W'(iss_stall), 16'h0001);
        step();
        iss_v = 1'b0;
        we0 = 1'b1; wa0 = 3; wd0 = 16'h0055;
        #1;
        chk("pend_r3_bypass_clear", W'(rpend[3]), 16'h0000);
        chk("rd_r3_bypass", rdp(3), 16'h0055);
        step();
        idle_writes();
        #1;
        chk("pend_r3_cleared", W'(rpend[3]), 16'h0000);
        iss_v = 1'b1; iss_a = 3;
        we1 = 1'b1; wa1 = 3; wd1 = 16'h0066;
        #1;
        chk("stall_none_when_written", W'(iss_stall), 16'h0000);
        step();
        idle_writes();
        #1;
        chk("pend_r3_issue_wins", W'(rpend[3]), 16'h0001);
        chk("rd_r3_stored", rdp(3), 16'h0066);

        // Issue to register 0 never marks it pending.
        iss_v = 1'b1; iss_a = 0;
        set_ra(0, 0, 0, 3);
        step();
        iss_v = 1'b0;
        #1;
        chk("pend_r0_never", W'(rpend[0]), 16'h0000);

        // Fill registers 1..7 and read them back over all ports.
        for (int r = 1; r < D; r++) begin
            we0 = 1'b1; wa0 = AW'(r); wd0 = W'(r * 16'h0111);
            step();
        end
        idle_writes();
        for (int r = 1; r < D; r++) begin
            set_ra(AW'(r), AW'(r), AW'(r), AW'(r));
            #1;
            chk("fill_port0", rdp(0), W'(r * 16'h0111));
            chk("fill_port3", rdp(3), W'(r * 16'h0111));
        end

        // Pending on 3 and 7 with data, then a mid-cycle reset wipes everything at once.
        step();
        iss_v = 1'b1; iss_a = 7;
        step();
        iss_v = 1'b1; iss_a = 3;
        step();
        iss_v = 1'b1; iss_a = 3;
        set_ra(3, 7, 5, 2);
        #1;
        chk("pre_rst_rd7", rdp(1), 16'h0777);
        chk("pre_rst_rpend", W'(rpend), 16'h0003);
        chk("pre_rst_stall", W'(iss_stall), 16'h0001);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd0", rdp(0), 16'h0000);
        chk("mid_rst_rd1", rdp(1), 16'h0000);
        chk("mid_rst_rd2", rdp(2), 16'h0000);
        chk("mid_rst_rd3", rdp(3), 16'h0000);
        chk("mid_rst_rpend", W'(rpend), 16'h0000);
        chk("mid_rst_stall", W'(iss_stall), 16'h0000);
        idle_writes();
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_rd7", rdp(1), 16'h0000);
        chk("post_rst_rpend", W'(rpend), 16'h0000);

        // First edge after reset accepts a write normally.
        we1 = 1'b1; wa1 = 7; wd1 = 16'hBEEF;
        step();
        idle_writes();
        #1;
        chk("post_rst_write_r7", rdp(1), 16'hBEEF);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 32, data bits per register.
REQ-002 Parameter DEPTH, default 32, register count (power of two, >= 2); AW = clog2(DEPTH) is derived, not overridable.
REQ-003 Parameter NREAD, default 2, number of read ports (1..4).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 ra  input  NREAD*AW  packed read addresses; port i at bits [i*AW +: AW].
REQ-007 rd  output  NREAD*WIDTH  packed read data; port i at bits [i*WIDTH +: WIDTH].
REQ-008 rpend  output  NREAD  port i's register has an outstanding pending write.
REQ-009 we0 / wa0 / wd0  input  1 / AW / WIDTH  write port 0: enable, address, data.
REQ-010 we1 / wa1 / wd1  input  1 / AW / WIDTH  write port 1: enable, address, data.
REQ-011 iss_v / iss_a  input  1 / AW  issue: mark register iss_a pending (scoreboard set).
REQ-012 iss_stall  output  1  iss_a is already pending and not being written this cycle.

Function
REQ-013 Reads are combinational (zero latency) from ra; no read-enable.
REQ-014 Address 0 reads WIDTH'b0 always; writes to address 0 are discarded; address 0 is never pending.
REQ-015 A write with weN=1 to a nonzero address updates that register at the rising edge.
REQ-016 Same-cycle bypass: if ra[i] equals an enabled nonzero write address, rd[i] returns that write's data in the same cycle.
REQ-017 Both ports enabled, same nonzero address: port 1 wins for storage and for bypass.
REQ-018 weN=0 leaves storage unchanged regardless of waN/wdN, and no bypass occurs.
REQ-019 Scoreboard: one pending bit per register; iss_v=1 with nonzero iss_a sets bit iss_a at the edge.
REQ-020 An enabled write to a nonzero address clears its pending bit at the edge.
REQ-021 Issue and write to the same register in the same cycle: pending ends set (issue wins).
REQ-022 rpend[i] = pending bit of ra[i], with bypass: reads 0 if that register is written this cycle; always 0 for address 0.
REQ-023 iss_stall = iss_v AND pending[iss_a] AND no enabled write to iss_a this cycle; it is combinational.
REQ-024 The block does not suppress issue when iss_stall=1; the issuer must hold off, and a stalled issue leaves the bit set.
REQ-025 Out-of-range addresses cannot occur (DEPTH is a power of two).

Reset
REQ-026 rst_n=0 asynchronously clears every register to 0 and every pending bit to 0.
REQ-027 During reset, rd is all zero, rpend is all zero, and iss_stall=0; write and issue inputs are ignored.
REQ-028 The first edge after rst_n rises accepts writes and issues normally; a reset mid-sequence discards all pending state.

Structure
REQ-029 Shared package/header holds default WIDTH/DEPTH/NREAD, the zero-register index constant and the AW derivation function.
REQ-030 One sub-module is natural: regfile_rdport (one address in; storage, both write ports and the pending vector in; rd/rpend out). It is instantiated NREAD times via generate.
REQ-031 Storage and pending bits reside in the top module; there are no latches and no multi-driven nets.

Verification
REQ-032 Reset, then we0=1 wa0=0 wd0=13 and ra[0]=0 -> rd[0]=0 before and after the edge.
REQ-033 we0=1 wa0=2 wd0=94 and ra[1]=2 -> rd[1]=94 in the same cycle (bypass); it is still 94 after the edge with we0=0.
REQ-034 we0=0 wa0=4 wd0=100 for one cycle, ra[0]=4 -> rd[0]=0; then change ra with no clock -> rd tracks immediately (asynchronous read).
REQ-035 we0=1 wa0=5 wd0=7 with we1=1 wa1=5 wd1=9 -> bypass gives 9; the stored value after the edge is 9.
REQ-036 Issue reg 3 -> rpend=1 for ra=3, and a re-issue of 3 gives iss_stall=1; write reg 3 with 0x55 -> rpend=0 the same cycle; simultaneous issue plus write of 3 -> pending=1 after the edge.
REQ-037 Pending bits set on regs 3 and 7 with data written, then rst_n pulsed low mid-cycle -> immediately all rd=0 and rpend=0; run at NREAD=4, WIDTH=16, DEPTH=8.
